// File: rtl/player_health_manager.sv
// Match-state producer for the character/health display: tracks both players'
// characters and health through SELECT/PLAY/OVER and applies hit and ultimate damage.
module player_health_manager #(
    parameter logic [3:0] MAX_HEALTH    = 4'd10,
    parameter logic [3:0] HIT_DAMAGE    = 4'd1,
    parameter logic [3:0] ULT_DAMAGE    = 4'd3,
    parameter int         INVULN_CYCLES = 50000000,
    parameter int         CNT_W         = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  p1_char_sel,
    input  logic [1:0]  p2_char_sel,
    input  logic        start,
    input  logic        p1_hit,
    input  logic        p2_hit,
    input  logic        p1_clear_ult,
    input  logic        p2_clear_ult,
    output logic [11:0] health_data,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        p1_invuln,
    output logic        p2_invuln
);

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_PLAY   = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state, state_next;
    logic [1:0]       p1_char, p1_char_next, p2_char, p2_char_next;
    logic [3:0]       p1_health, p1_health_next, p2_health, p2_health_next;
    logic [CNT_W-1:0] p1_cnt, p1_cnt_next, p2_cnt, p2_cnt_next;
    logic             game_over_next;
    logic [1:0]       winner_next;

    logic             p1_hit_ok, p2_hit_ok;
    logic [4:0]       p1_dmg, p2_dmg;
    logic [3:0]       p1_new, p2_new;

    // Health saturates at zero; damage is 5 bits so HIT+ULT never wraps.
    function automatic logic [3:0] apply_dmg(input logic [3:0] hp, input logic [4:0] dmg);
        return (dmg >= {1'b0, hp}) ? 4'd0 : hp - dmg[3:0];
    endfunction

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt, input logic [4:0] dmg);
        if (dmg != 5'd0)
            return CNT_LOAD;
        else if (cnt != CNT_ZERO)
            return cnt - CNT_ONE;
        else
            return CNT_ZERO;
    endfunction

    assign p1_hit_ok = p1_hit && (p1_cnt == CNT_ZERO);
    assign p2_hit_ok = p2_hit && (p2_cnt == CNT_ZERO);
    // Ultimates bypass the invulnerability window; only projectile hits are gated.
    assign p1_dmg = (p1_hit_ok ? {1'b0, HIT_DAMAGE} : 5'd0) + (p2_clear_ult ? {1'b0, ULT_DAMAGE} : 5'd0);
    assign p2_dmg = (p2_hit_ok ? {1'b0, HIT_DAMAGE} : 5'd0) + (p1_clear_ult ? {1'b0, ULT_DAMAGE} : 5'd0);
    assign p1_new = apply_dmg(p1_health, p1_dmg);
    assign p2_new = apply_dmg(p2_health, p2_dmg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SELECT;
            p1_char   <= 2'b00;
            p2_char   <= 2'b00;
            p1_health <= MAX_HEALTH;
            p2_health <= MAX_HEALTH;
            p1_cnt    <= CNT_ZERO;
            p2_cnt    <= CNT_ZERO;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else begin
            state     <= state_next;
            p1_char   <= p1_char_next;
            p2_char   <= p2_char_next;
            p1_health <= p1_health_next;
            p2_health <= p2_health_next;
            p1_cnt    <= p1_cnt_next;
            p2_cnt    <= p2_cnt_next;
            game_over <= game_over_next;
            winner    <= winner_next;
        end
    end

    always_comb begin
        state_next     = state;
        p1_char_next   = p1_char;
        p2_char_next   = p2_char;
        p1_health_next = p1_health;
        p2_health_next = p2_health;
        p1_cnt_next    = p1_cnt;
        p2_cnt_next    = p2_cnt;
        game_over_next = game_over;
        winner_next    = winner;

        case (state)
            S_SELECT: begin
                // Tracking also covers the start edge, so the chars freeze at that sample.
                p1_char_next   = p1_char_sel;
                p2_char_next   = p2_char_sel;
                p1_health_next = MAX_HEALTH;
                p2_health_next = MAX_HEALTH;
                p1_cnt_next    = CNT_ZERO;
                p2_cnt_next    = CNT_ZERO;
                if (start)
                    state_next = S_PLAY;
            end
            S_PLAY: begin
                p1_health_next = p1_new;
                p2_health_next = p2_new;
                p1_cnt_next    = next_cnt(p1_cnt, p1_dmg);
                p2_cnt_next    = next_cnt(p2_cnt, p2_dmg);
                if ((p1_new == 4'd0) || (p2_new == 4'd0)) begin
                    state_next     = S_OVER;
                    game_over_next = 1'b1;
                    winner_next    = {p1_new == 4'd0, p2_new == 4'd0};
                end
            end
            S_OVER: begin
                p1_cnt_next = CNT_ZERO;
                p2_cnt_next = CNT_ZERO;
                if (start) begin
                    state_next     = S_SELECT;
                    p1_health_next = MAX_HEALTH;
                    p2_health_next = MAX_HEALTH;
                    game_over_next = 1'b0;
                    winner_next    = 2'b00;
                end
            end
            default: state_next = S_SELECT;
        endcase
    end

    assign health_data = {p1_char, p1_health, p2_char, p2_health};
    assign p1_invuln   = (p1_cnt != CNT_ZERO);
    assign p2_invuln   = (p2_cnt != CNT_ZERO);

endmodule

// File: tb/tb_player_health_manager.sv
// Bench for player_health_manager: per-cycle expected outputs from an arithmetic
// match model are queued by the driver and popped by an independent monitor.
module tb_player_health_manager;

    localparam int INV  = 4;
    localparam int MAXH = 10;
    localparam int HIT  = 1;
    localparam int ULT  = 3;
    localparam int FAR  = -1000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  p1_char_sel, p2_char_sel;
    logic        start, p1_hit, p2_hit, p1_clear_ult, p2_clear_ult;
    logic [11:0] health_data;
    logic        game_over;
    logic [1:0]  winner;
    logic        p1_invuln, p2_invuln;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];

    // Match model: phase 0 select, 1 play, 2 over; invulnerability from the last damage cycle.
    int m_phase, m_c1, m_c2, m_hp1, m_hp2, m_go, m_win, m_ld1, m_ld2;
    int cyc = 0;

    player_health_manager #(
        .MAX_HEALTH(4'd10), .HIT_DAMAGE(4'd1), .ULT_DAMAGE(4'd3),
        .INVULN_CYCLES(INV), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .p1_char_sel(p1_char_sel), .p2_char_sel(p2_char_sel),
        .start(start), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_clear_ult(p1_clear_ult), .p2_clear_ult(p2_clear_ult),
        .health_data(health_data), .game_over(game_over), .winner(winner),
        .p1_invuln(p1_invuln), .p2_invuln(p2_invuln)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic [1:0] s1, input logic [1:0] s2,
                              input logic st, input logic h1, input logic h2,
                              input logic u1, input logic u2);
        int d1, d2, n1, n2;
        if (r) begin
            m_phase = 0; m_c1 = 0; m_c2 = 0; m_hp1 = MAXH; m_hp2 = MAXH;
            m_go = 0; m_win = 0; m_ld1 = FAR; m_ld2 = FAR;
        end else if (m_phase == 0) begin
            m_c1 = s1; m_c2 = s2; m_hp1 = MAXH; m_hp2 = MAXH;
            m_ld1 = FAR; m_ld2 = FAR;
            if (st) m_phase = 1;
        end else if (m_phase == 1) begin
            d1 = ((h1 && (cyc - m_ld1 >= INV)) ? HIT : 0) + (u2 ? ULT : 0);
            d2 = ((h2 && (cyc - m_ld2 >= INV)) ? HIT : 0) + (u1 ? ULT : 0);
            n1 = (m_hp1 - d1 < 0) ? 0 : m_hp1 - d1;
            n2 = (m_hp2 - d2 < 0) ? 0 : m_hp2 - d2;
            if (d1 > 0) m_ld1 = cyc;
            if (d2 > 0) m_ld2 = cyc;
            m_hp1 = n1; m_hp2 = n2;
            if (n1 == 0 || n2 == 0) begin
                m_phase = 2; m_go = 1;
                m_win = (n1 == 0 && n2 == 0) ? 3 : ((n2 == 0) ? 1 : 2);
            end
        end else begin
            m_ld1 = FAR; m_ld2 = FAR;
            if (st) begin
                m_phase = 0; m_hp1 = MAXH; m_hp2 = MAXH; m_go = 0; m_win = 0;
            end
        end
    endtask

    function automatic logic [16:0] model_out();
        logic i1, i2;
        i1 = (cyc - m_ld1) <= INV - 2;
        i2 = (cyc - m_ld2) <= INV - 2;
        return {2'(m_c1), 4'(m_hp1), 2'(m_c2), 4'(m_hp2), 1'(m_go), 2'(m_win), i1, i2};
    endfunction

    // Driver: called at a falling edge; inputs are consumed by the next rising edge.
    task automatic step(input logic r, input logic [1:0] s1, input logic [1:0] s2,
                        input logic st, input logic h1, input logic h2,
                        input logic u1, input logic u2);
        reset = r; p1_char_sel = s1; p2_char_sel = s2; start = st;
        p1_hit = h1; p2_hit = h2; p1_clear_ult = u1; p2_clear_ult = u2;
        model_step(r, s1, s2, st, h1, h2, u1, u2);
        exp_q.push_back(model_out());
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, p1_char_sel, p2_char_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string name, input logic [16:0] act, input logic [16:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh registered state; compare with the queue head.
    initial begin
        logic [16:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {health_data, game_over, winner, p1_invuln, p2_invuln};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL cycle_state @%0t: got hd=%b go=%b win=%b inv=%b%b required hd=%b go=%b win=%b inv=%b%b",
                             $time, a[16:5], a[4], a[3:2], a[1], a[0], e[16:5], e[4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Reset, then select chars 10/01 and start.
        step(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_state", {health_data, game_over, winner, p1_invuln, p2_invuln},
                  {12'b00_1010_00_1010, 1'b0, 2'b00, 2'b00});
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("start_play", {5'b0, health_data}, {5'b0, 12'b10_1010_01_1010});
        step(1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("chars_frozen", {5'b0, health_data}, {5'b0, 12'b10_1010_01_1010});

        // Invulnerability window: hits at t, t+2 (dropped), t+4 (accepted).
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("p1_first_hit", {12'b0, 4'(health_data[9:6]), p1_invuln}, {12'b0, 4'd9, 1'b1});
        idle(1);
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("p1_hit_dropped", {12'b0, 4'(health_data[9:6]), p1_invuln}, {12'b0, 4'd9, 1'b1});
        idle(1);
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("p1_hit_after_window", {13'b0, health_data[9:6]}, {13'b0, 4'd8});

        // Ult lands through p2 invulnerability; simultaneous hit is dropped.
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("ult_through_invuln", {12'b0, health_data[3:0], p2_invuln}, {12'b0, 4'd6, 1'b1});

        // Drive p1 from 8 to 0 with ults: 8 -> 5 -> 2 -> 0.
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("p1_killed", {health_data, game_over, winner, 2'b00},
                  {12'b10_0000_01_0110, 1'b1, 2'b10, 2'b00});
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("over_frozen", {health_data, game_over, winner, p1_invuln, p2_invuln},
                  {12'b10_0000_01_0110, 1'b1, 2'b10, 2'b00});

        // Back to SELECT, new match, both to 1 then simultaneous hits -> draw.
        step(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("both_at_one", {5'b0, health_data}, {5'b0, 12'b11_0001_00_0001});
        idle(INV);
        step(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("draw", {health_data, game_over, winner, 2'b00},
                  {12'b11_0000_00_0000, 1'b1, 2'b11, 2'b00});
        step(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("restart_select", {health_data, game_over, winner, 2'b00},
                  {12'b11_1010_00_1010, 1'b0, 2'b00, 2'b00});

        // Reset mid-play with counters running, start also asserted.
        step(1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b01, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("mid_play_reset", {health_data, game_over, winner, p1_invuln, p2_invuln},
                  {12'b00_1010_00_1010, 1'b0, 2'b00, 2'b00});

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
